// File: rtl/deser_pkg.sv
// Shared types and constants for the serial nibble deserializer.
package deser_pkg;

  // Frame-alignment state: searching for a strobe, or tracking frames.
  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Output buffer depth; the FIFO pointers are 1 bit wide because of this.
  localparam int FIFO_DEPTH = 2;

  // Width of the optional saturating error counter.
  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/nibble_fifo2.sv
// Two-entry first-word-fall-through FIFO with 1-bit pointers and a 2-bit count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module nibble_fifo2
  import deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == 2'd0);
  assign full      = (r_count == FULL_CNT);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  // Head reads as zero when empty so out_data is clean after reset.
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_nibble_deser.sv
// Serial-to-parallel deserializer with HUNT/LOCK frame alignment and a
// 2-entry output buffer. Define DESER_ERR_CNT_EN to add the saturating
// err_cnt output that counts cycles with frame_err or ovf asserted.
module serial_nibble_deser
  import deser_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  output logic                 locked,
  output logic                 frame_err,
`ifdef DESER_ERR_CNT_EN
  output logic                 ovf,
  output logic [ERR_CNT_W-1:0] err_cnt
`else
  output logic                 ovf
`endif
);

  localparam int              CW       = (W > 1) ? $clog2(W) : 1;
  localparam int              SW       = W - 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_shift;     // bits of the current frame received so far
  logic            r_frame_err;
  logic            r_ovf;

  state_t          w_state_next;
  logic [CW-1:0]   w_cnt_next;
  logic [SW-1:0]   w_shift_next;
  logic [SW-1:0]   w_start;     // shift contents after a frame-start bit
  logic [W-1:0]    w_word;      // completed word when this bit is the LSB
  logic            w_push;
  logic            w_pop;
  logic            w_ferr_next;
  logic            w_full;
  logic            w_empty;

  assign w_start = SW'(din);
  assign w_word  = {r_shift, din};

  // State, bit counter, assembly register and registered fault pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_shift     <= w_shift_next;
      r_frame_err <= w_ferr_next;
      r_ovf       <= w_push && w_full && !w_pop;
    end
  end

  // Frame alignment: strobe handling, bit assembly and word completion.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_push       = 1'b0;
    w_ferr_next  = 1'b0;
    case (r_state)
      HUNT: begin
        if (din_valid) begin
          w_state_next = LOCK;
          w_cnt_next   = CNT_ONE;
          w_shift_next = w_start;
        end
      end
      LOCK: begin
        if (r_cnt == '0) begin
          if (din_valid) begin
            w_cnt_next   = CNT_ONE;
            w_shift_next = w_start;
          end else begin
            // Missing strobe: lose alignment and drop this bit.
            w_ferr_next  = 1'b1;
            w_state_next = HUNT;
            w_cnt_next   = '0;
            w_shift_next = '0;
          end
        end else if (din_valid) begin
          // Early strobe: abandon the partial word and restart here.
          w_ferr_next  = 1'b1;
          w_cnt_next   = CNT_ONE;
          w_shift_next = w_start;
        end else begin
          w_shift_next = SW'(w_word);
          if (r_cnt == CNT_LAST) begin
            w_push     = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        w_state_next = HUNT;
        w_cnt_next   = '0;
        w_shift_next = '0;
      end
    endcase
  end

  assign w_pop = !w_empty && out_ready;

  nibble_fifo2 #(
    .WIDTH(W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_word),
    .rdata (out_data),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign locked    = (r_state == LOCK);
  assign frame_err = r_frame_err;
  assign ovf       = r_ovf;

`ifdef DESER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Saturating count of cycles showing a fault pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if ((r_frame_err || r_ovf) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_serial_nibble_deser.sv
// Directed bench for serial_nibble_deser (W=4). Inputs change 1ns after the
// rising edge; outputs are checked at the same point, i.e. mid-cycle.
module tb_serial_nibble_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       locked;
  logic       frame_err;
  logic       ovf;
`ifdef DESER_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int   total = 0;
  int   bad   = 0;
  logic ferr_seen;
  logic ovf_seen;

  serial_nibble_deser #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .locked    (locked),
    .frame_err (frame_err),
`ifdef DESER_ERR_CNT_EN
    .ovf       (ovf),
    .err_cnt   (err_cnt)
`else
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // One clock: apply serial inputs, advance past the edge, note fault pulses.
  task automatic step(input logic d, input logic v);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
    ferr_seen = ferr_seen | frame_err;
    ovf_seen  = ovf_seen | ovf;
  endtask

  // Send a nibble MSB first; rdy[3] is out_ready for the MSB cycle.
  task automatic send_frame(input logic [3:0] nib, input logic strobe, input logic [3:0] rdy);
    for (int i = 0; i < 4; i++) begin
      out_ready = rdy[3-i];
      step(nib[3-i], (i == 0) && strobe);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    ferr_seen = 1'b0;
    ovf_seen  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; out_ready = 1'b1;
    ferr_seen = 1'b0; ovf_seen = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_valid",  32'(out_valid), 32'd0);
    check("rst_data",   32'(out_data),  32'd0);
    check("rst_locked", 32'(locked),    32'd0);
    check("rst_ferr",   32'(frame_err), 32'd0);
    check("rst_ovf",    32'(ovf),       32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    check("hunt_idle_locked", 32'(locked), 32'd0);

    // Back-to-back frames A, 5, F.
    ferr_seen = 1'b0;
    step(1'b1, 1'b1);
    check("t1_locked", 32'(locked), 32'd1);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    check("t1_valid_a", 32'(out_valid), 32'd1);
    check("t1_data_a",  32'(out_data),  32'hA);
    send_frame(4'h5, 1'b1, 4'hF);
    check("t1_data_5",  32'(out_data),  32'h5);
    send_frame(4'hF, 1'b1, 4'hF);
    check("t1_valid_f", 32'(out_valid), 32'd1);
    check("t1_data_f",  32'(out_data),  32'hF);
    check("t1_no_ferr", 32'(ferr_seen), 32'd0);

    // Missing strobe, then relock.
    send_frame(4'h3, 1'b1, 4'hF);
    check("t2_data_3", 32'(out_data), 32'h3);
    step(1'b0, 1'b0);
    check("t2_ferr",   32'(frame_err), 32'd1);
    check("t2_unlock", 32'(locked),    32'd0);
    step(1'b0, 1'b0);
    check("t2_ferr_one", 32'(frame_err), 32'd0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("t2_hunt_empty", 32'(out_valid), 32'd0);
    send_frame(4'h6, 1'b1, 4'hF);
    check("t2_relock",  32'(locked),    32'd1);
    check("t2_valid_6", 32'(out_valid), 32'd1);
    check("t2_data_6",  32'(out_data),  32'h6);

    // Early strobe two cycles into a frame.
    step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("t3_ferr",   32'(frame_err), 32'd1);
    check("t3_locked", 32'(locked),    32'd1);
    step(1'b0, 1'b0);
    check("t3_no_partial", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0); step(1'b1, 1'b0);
    check("t3_valid_9", 32'(out_valid), 32'd1);
    check("t3_data_9",  32'(out_data),  32'h9);

    // Overflow: third word dropped while stalled.
    reset_dut();
    send_frame(4'h1, 1'b1, 4'h0);
    send_frame(4'h2, 1'b1, 4'h0);
    check("t4_no_early_ovf", 32'(ovf_seen), 32'd0);
    send_frame(4'h3, 1'b1, 4'h0);
    check("t4_ovf",    32'(ovf),      32'd1);
    check("t4_head_1", 32'(out_data), 32'h1);
    out_ready = 1'b1;
    step(1'b0, 1'b0);
    check("t4_ovf_one", 32'(ovf),      32'd0);
    check("t4_data_2",  32'(out_data), 32'h2);
    step(1'b0, 1'b0);
    check("t4_drained", 32'(out_valid), 32'd0);

    // Full buffer: pop and push in the same cycle.
    reset_dut();
    send_frame(4'hC, 1'b1, 4'h0);
    send_frame(4'hD, 1'b1, 4'h0);
    ovf_seen = 1'b0;
    send_frame(4'hE, 1'b1, 4'h1);
    check("t5_no_ovf", 32'(ovf_seen),  32'd0);
    check("t5_data_d", 32'(out_data),  32'hD);
    out_ready = 1'b1;
    step(1'b0, 1'b0);
    check("t5_data_e", 32'(out_data),  32'hE);
    step(1'b0, 1'b0);
    check("t5_empty",  32'(out_valid), 32'd0);

    // Reset mid-frame with one word buffered.
    reset_dut();
    send_frame(4'h7, 1'b1, 4'h0);
    check("t6_buf_7", 32'(out_data), 32'h7);
    step(1'b1, 1'b1); step(1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0);
    check("t6_rst_valid",  32'(out_valid), 32'd0);
    check("t6_rst_data",   32'(out_data),  32'd0);
    check("t6_rst_locked", 32'(locked),    32'd0);
    check("t6_rst_ferr",   32'(frame_err), 32'd0);
    check("t6_rst_ovf",    32'(ovf),       32'd0);
    rst = 1'b0;
    send_frame(4'hB, 1'b1, 4'hF);
    check("t6_valid_b", 32'(out_valid), 32'd1);
    check("t6_data_b",  32'(out_data),  32'hB);

`ifdef DESER_ERR_CNT_EN
    // A strobe every cycle in LOCK is an early strobe each time.
    reset_dut();
    check("t7_cnt_rst", 32'(err_cnt), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 310; i++) step(1'b0, 1'b1);
    check("t7_cnt_sat", 32'(err_cnt), 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
